// File: rtl/audio_mavg_filter.sv
// rtl/audio_mavg_filter.sv - multi-channel moving-average (boxcar) low-pass filter
//
// Each channel keeps a DEPTH-deep circular history and a full-precision running
// sum. The output is the floor average of the window, registered one cycle
// after the sample is accepted. All channels share one valid/ready handshake.
module audio_mavg_filter #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3,
  parameter int CHANNELS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         bypass,
  input  logic                         flush,
  output logic                         primed
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  // The sum of DEPTH samples always fits in DATA_W + LOG2_DEPTH signed bits.
  localparam int SUM_W = DATA_W + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH:0]   FILL_ONE = (LOG2_DEPTH + 1)'(1);
  localparam logic [LOG2_DEPTH:0]   FILL_MAX = {1'b1, {LOG2_DEPTH{1'b0}}};

  // Shared window bookkeeping
  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;

  // Output register
  logic                       out_valid_q, out_valid_d;
  logic [CHANNELS*DATA_W-1:0] out_data_q;
  logic [CHANNELS*DATA_W-1:0] out_data_d;

  logic accept;

  // Handshake and next-state for the shared pointer, fill count and valid flag
  always_comb begin
    in_ready    = (!out_valid_q || out_ready) && !flush;
    accept      = in_valid && in_ready;
    wptr_d      = wptr_q + PTR_ONE;
    fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Write pointer and fill count; flush restarts the window like reset does
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else if (accept) begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end

  // Per-channel history, running sum and averaged result
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_W-1:0]                 x;
    logic [DATA_W-1:0]                 oldest;
    logic [SUM_W-1:0]                  x_ext;
    logic [SUM_W-1:0]                  oldest_ext;
    logic [SUM_W-1:0]                  sum_q, sum_d;
    logic [DEPTH-1:0][DATA_W-1:0]      hist_q;
    logic [DATA_W-1:0]                 avg;

    assign x          = in_data[c*DATA_W +: DATA_W];
    // The slot about to be overwritten holds the sample leaving the window.
    assign oldest     = hist_q[wptr_q];
    assign x_ext      = {{LOG2_DEPTH{x[DATA_W-1]}}, x};
    assign oldest_ext = {{LOG2_DEPTH{oldest[DATA_W-1]}}, oldest};

    // Running sum after this sample enters and the oldest one leaves
    always_comb begin
      sum_d = sum_q + x_ext - oldest_ext;
    end

    // Dropping the low LOG2_DEPTH bits of a two's-complement sum is the
    // arithmetic shift, i.e. floor toward negative infinity; the remaining
    // bits always fit in DATA_W.
    assign avg = sum_d[SUM_W-1:LOG2_DEPTH];

    assign out_data_d[c*DATA_W +: DATA_W] = bypass ? x : avg;

    // History and running sum; history keeps updating during bypass so the
    // average is correct as soon as bypass drops
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        hist_q <= '0;
        sum_q  <= '0;
      end else if (accept) begin
        hist_q[wptr_q] <= x;
        sum_q          <= sum_d;
      end
    end
  end

  // Output register: loads on accept, holds under backpressure, drains on ready
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = (fill_q == FILL_MAX);

endmodule

// File: doc/audio_mavg_filter.md
Name: audio_mavg_filter

Overview:
- Parametrised multi-channel moving-average (boxcar) low-pass filter for the audio codec sample path.
- Sits between the codec read interface and the codec write interface.
- Keeps a DEPTH-sample circular history and a full-precision running sum per channel; output is the exact floor average.
- Adds valid/ready flow control, bypass mode, synchronous history flush, and a primed status flag.

Parameters:
- DATA_W, 24: signed sample width per channel.
- LOG2_DEPTH, 3: log2 of window length; DEPTH = 2**LOG2_DEPTH; legal range 1..10.
- CHANNELS, 2: independent channels sharing one handshake; channel 0 occupies the LSBs of the packed buses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  CHANNELS*DATA_W  signed input samples, packed
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts a sample this cycle
- out_data  out  CHANNELS*DATA_W  signed averaged samples, packed
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- bypass  in  1  pass input straight to output; history still updates
- flush  in  1  clear history, running sums and fill count
- primed  out  1  window is full (fill count == DEPTH)

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - History, sums, write pointer and fill count = 0.
  - out_data = 0, out_valid = 0, primed = 0.
- in_ready = (!out_valid || out_ready) && !flush. This is combinational.
- accept = in_valid && in_ready.
- On accept, per channel c (all channels update together):
  - sum_c <= sum_c + x_c - hist_c[wptr], where x_c is the sign-extended input.
  - hist_c[wptr] <= x_c.
  - wptr <= wptr + 1, wrapping modulo DEPTH.
  - fill <= min(fill + 1, DEPTH).
- Output register (latency 1 cycle from accept):
  - On accept: out_valid <= 1.
  - out_data_c <= bypass ? x_c : (sum_c_next >>> LOG2_DEPTH).
  - bypass is sampled in the accept cycle.
- If out_valid && out_ready && !accept: out_valid <= 0.
- Output is held stable while out_valid && !out_ready. Full throughput is 1 sample per cycle when out_ready stays high.
- Arithmetic:
  - sum width is DATA_W + LOG2_DEPTH, signed, and never overflows.
  - The divide is an arithmetic right shift, i.e. floor toward negative infinity.
  - No per-tap truncation. The result always fits in DATA_W.
- Warm-up: history starts at zero, so the first DEPTH outputs average the received samples with zeros. primed rises in the cycle after the DEPTH-th accept.
- flush (synchronous):
  - Clears history, sums, wptr, fill and primed on the next edge.
  - Leaves out_data and out_valid untouched; a pending output may still drain.
  - in_ready is low during flush, so no sample is lost.
- reset and flush together: reset wins. reset mid-stream drops any pending output.
- bypass toggling: takes effect on the next accept. The average stays correct because history updated during bypass.

Test Plan:
- Reset, then LOG2_DEPTH=3, ch0 = 7 for 10 consecutive accepts with out_ready=1 -> out ch0 = 0,1,2,3,4,5,6,7,7,7. primed goes high after the 8th accept.
- One sample ch0 = -1, then 7 zero samples, then 1 more zero -> 8 outputs of -1 (floor), then 0 once -1 leaves the window. Also ch1 = +1 in the same 8-sample pattern -> ch1 = 0 throughout (channel independence).
- Saturation extremes: 8 samples of 0x7FFFFF, then 8 samples of 0x800000 -> outputs reach exactly 0x7FFFFF, then exactly 0x800000, with no wrap.
- Backpressure: out_ready=0 with in_valid=1 -> one output captured. in_ready=0 from the next cycle. out_data is held. Raising out_ready releases the data, and the stream resumes at 1 sample per cycle with no drop or duplicate.
- Bypass: feed 800 x8 with bypass=1 -> outputs are 800 each cycle. Then bypass=0 with 800 -> output 800 immediately (history already full).
- Flush after 8 samples of 800: pulse flush with in_valid=1 -> in_ready=0 during flush and primed drops. The next sample 800 outputs 100.
